imem_boot_loader: RTL and testbench

//  Writes a program image into instruction memory from a byte stream (valid/ready), then releases the CPU.

---
 rtl/imem_boot_loader_if.sv | 29 ++
 rtl/imem_boot_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write port of the boot loader, bundled.
// master: the loader itself (accepts bytes, drives the write port).
// slave:  the host byte source and the imem write port on the far side.
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a length-prefixed, XOR-checksummed
// byte frame, writes each big-endian word into imem and holds the CPU in reset
// until a clean image has been loaded.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// LEN_HI | expecting word count high byte
// LEN_LO | expecting word count low byte; range check of N
// DATA   | collecting the 4 bytes of the current word
// WRITE  | one-cycle imem write of the assembled word
// CHK    | expecting checksum byte, compared with XOR of data bytes
// DONE   | frame finished; done/error sticky until next start
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    imem_boot_loader_if.master         bus,
    output logic                       cpu_reset,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  acc_q, acc_d;

    logic        rx_ready_q, rx_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        take;
    logic [15:0] len_full;
    logic [31:0] word_full;
    logic [15:0] idx_inc;

    // A byte is consumed only when the registered ready meets a valid byte.
    assign take      = bus.rx_valid && rx_ready_q;
    assign len_full  = {len_q[15:8], bus.rx_data};
    assign word_full = {word_q[23:0], bus.rx_data};
    assign idx_inc   = idx_q + 16'd1;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            acc_q       <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state, datapath updates, and outputs decoded from the next state so
    // that each registered output matches the state it is presented in.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        acc_d       = acc_q;
        error_d     = error_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    error_d    = 1'b0;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    acc_d      = '0;
                end
            end
            S_LEN_HI: begin
                if (take) begin
                    len_d   = {bus.rx_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (take) begin
                    len_d = len_full;
                    if (32'(len_full) > MAX_WORDS) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    word_d     = word_full;
                    acc_d      = acc_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_addr_d  = BASE_ADDR + 32'(idx_q) * ADDR_STEP;
                        mem_wdata_d = word_full;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (take) begin
                    if (bus.rx_data != acc_q) begin
                        error_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      (state_d == S_DATA)   || (state_d == S_CHK);
        busy_d      = rx_ready_d || (state_d == S_WRITE);
        mem_we_d    = (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        cpu_reset_d = !((state_d == S_DONE) && !error_d);
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for the imem boot loader: directed frames plus randomized frames,
// each checked against a frame-level model (image words, XOR checksum).
module tb_imem_boot_loader;

    localparam logic [31:0] TB_BASE = 32'd0;
    localparam logic [31:0] TB_STEP = 32'd4;
    localparam int          TB_MAX  = 64;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset, busy, done, error;

    imem_boot_loader_if ifc ();

    imem_boot_loader #(
        .BASE_ADDR (TB_BASE),
        .ADDR_STEP (TB_STEP),
        .MAX_WORDS (TB_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (ifc),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] img[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Record every imem write the loader issues.
    always @(posedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            wr_addr.push_back(ifc.mem_addr);
            wr_data.push_back(ifc.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int k);
        return TB_BASE + 32'(k) * TB_STEP;
    endfunction

    // Build the byte frame for img[0..n-1]; optionally corrupt the checksum.
    task automatic build_frame(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] len;
        len = 16'(n);
        tx_q.delete();
        tx_q.push_back(len[15:8]);
        tx_q.push_back(len[7:0]);
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = img[k][31 - 8*j -: 8];
                tx_q.push_back(b);
                x = x ^ b;
            end
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        tx_q.push_back(x);
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int k = 0; k < n; k++) img.push_back($urandom());
    endtask

    // Called just after a negedge; leaves just after a negedge.
    task automatic pulse_start(input string tag);
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".start_busy"}, 32'(busy), 32'd1);
        chk({tag, ".start_done"}, 32'(done), 32'd0);
        chk({tag, ".start_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, ".start_ready"}, 32'(ifc.rx_ready), 32'd1);
    endtask

    // Push tx_q through the handshake with random gaps; after each byte check
    // the write pulse (only right after the 4th byte of a word).
    task automatic send_bytes(input string tag, input int n_words, input int max_gap);
        int wait_cnt;
        int gap;
        for (int i = 0; i < tx_q.size(); i++) begin
            gap = $urandom_range(0, max_gap);
            ifc.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = tx_q[i];
            wait_cnt = 0;
            while (ifc.rx_ready !== 1'b1 && wait_cnt < 50) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (wait_cnt >= 50) begin
                checks++;
                errors++;
                $error("FAIL %s.ready_timeout observed=byte%0d_not_taken expected=taken", tag, i);
                ifc.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
            ifc.rx_valid = 1'b0;
            if (i >= 2 && i < 2 + 4*n_words && ((i - 2) % 4) == 3) begin
                chk({tag, ".we_pulse"}, 32'(ifc.mem_we), 32'd1);
                chk({tag, ".we_addr"}, ifc.mem_addr, exp_addr((i - 2) / 4));
                chk({tag, ".we_data"}, ifc.mem_wdata, img[(i - 2) / 4]);
            end else begin
                chk({tag, ".we_idle"}, 32'(ifc.mem_we), 32'd0);
            end
        end
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, ".wr_count"}, 32'(wr_addr.size()), 32'(n));
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            chk({tag, ".wr_addr"}, wr_addr[k], exp_addr(k));
            chk({tag, ".wr_data"}, wr_data[k], img[k]);
        end
    endtask

    task automatic run_frame(input string tag, input int n, input bit bad, input int max_gap);
        build_frame(n, bad);
        pulse_start(tag);
        send_bytes(tag, n, max_gap);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".error"}, 32'(error), 32'(bad));
        chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(bad));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".ready"}, 32'(ifc.rx_ready), 32'd0);
        check_writes(tag, n);
    endtask

    task automatic run_len_fault(input string tag, input int n);
        logic [15:0] len;
        len = 16'(n);
        tx_q.delete();
        tx_q.push_back(len[15:8]);
        tx_q.push_back(len[7:0]);
        pulse_start(tag);
        send_bytes(tag, 0, 1);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".error"}, 32'(error), 32'd1);
        chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'hA5;
        repeat (3) begin
            chk({tag, ".ready_low"}, 32'(ifc.rx_ready), 32'd0);
            @(negedge clk);
        end
        ifc.rx_valid = 1'b0;
        chk({tag, ".no_writes"}, 32'(wr_addr.size()), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(ifc.rx_ready), 32'd0);
        chk("rst.we", 32'(ifc.mem_we), 32'd0);
        chk("rst.addr", ifc.mem_addr, TB_BASE);
        chk("rst.wdata", ifc.mem_wdata, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.error", 32'(error), 32'd0);
        chk("rst.cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("idle.cpu_reset", 32'(cpu_reset), 32'd1);

        // Two-word frame, back-to-back, good and bad checksum.
        img.delete();
        img.push_back(32'h20000005);
        img.push_back(32'h08000074);
        run_frame("good2", 2, 1'b0, 0);
        chk("good2.chk_byte", 32'(tx_q[10]), 32'h59);
        run_frame("badchk", 2, 1'b1, 0);

        // Length over the limit, then exactly at the limit.
        run_len_fault("len65", TB_MAX + 1);
        random_image(TB_MAX);
        run_frame("len64", TB_MAX, 1'b0, 0);

        // One word with 3 idle cycles between bytes.
        img.delete();
        img.push_back(32'h01020304);
        build_frame(1, 1'b0);
        pulse_start("gap3");
        for (int i = 0; i < tx_q.size(); i++) begin
            ifc.rx_valid = 1'b0;
            repeat (3) @(negedge clk);
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = tx_q[i];
            @(negedge clk);
        end
        ifc.rx_valid = 1'b0;
        chk("gap3.done", 32'(done), 32'd1);
        chk("gap3.error", 32'(error), 32'd0);
        chk("gap3.cpu_reset", 32'(cpu_reset), 32'd0);
        check_writes("gap3", 1);

        // Empty image.
        img.delete();
        run_frame("n0", 0, 1'b0, 1);

        // Reset mid-frame after 6 data bytes.
        random_image(2);
        build_frame(2, 1'b0);
        while (tx_q.size() > 8) void'(tx_q.pop_back());
        pulse_start("midrst");
        send_bytes("midrst", 2, 0);
        repeat (2) @(negedge clk);
        chk("midrst.pre_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst.we", 32'(ifc.mem_we), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.ready", 32'(ifc.rx_ready), 32'd0);
        chk("midrst.cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst.addr", ifc.mem_addr, TB_BASE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_writes("midrst", 1);
        run_frame("after_rst", 2, 1'b0, 1);

        // Randomized frames.
        for (int r = 0; r < 14; r++) begin
            int n;
            n = $urandom_range(0, 6);
            random_image(n);
            run_frame("rnd", n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end
        for (int r = 0; r < 3; r++) begin
            run_len_fault("rnd_len", $urandom_range(TB_MAX + 1, 65535));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
